// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared ALU.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   rN_req/in1/in2/op     requester N operation (held until rN_gnt)
//   rN_gnt                one-cycle combinational grant in IDLE
//   alu_in1/in2/op        ALU operands, driven only in EXEC, else 0
//   alu_flag_in           current architectural flags to the ALU
//   alu_out/alu_flag      ALU result and flags ({Z,V,N})
//   rsp_valid/id/data     one-cycle response with the registered result
//   flag_q                architectural flag register ({Z,V,N})
//   busy                  high whenever the FSM is not in IDLE
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic [15:0] r0_in1,
    input  logic [15:0] r0_in2,
    input  logic [2:0]  r0_op,
    input  logic        r1_req,
    input  logic [15:0] r1_in1,
    input  logic [15:0] r1_in2,
    input  logic [2:0]  r1_op,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [2:0]  alu_op,
    output logic [2:0]  alu_flag_in,
    input  logic [15:0] alu_out,
    input  logic [2:0]  alu_flag,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic [2:0]  flag_q,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] in1_q, in1_d;
    logic [15:0] in2_q, in2_d;
    logic [2:0]  op_q, op_d;
    logic        id_q, id_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  stage_q, stage_d;
    logic [2:0]  flags_q, flags_d;

    logic        gnt0, gnt1;
    logic [2:0]  upd_mask;

    // Which flag bits an opcode is allowed to write ({Z,V,N}).
    always_comb begin
        upd_mask = 3'b000;
        unique case (op_q)
            3'b000, 3'b001:                 upd_mask = 3'b111;
            3'b010, 3'b100, 3'b101, 3'b110: upd_mask = 3'b100;
            default:                        upd_mask = 3'b000;
        endcase
    end

    // Round-robin pick: a lone requester wins; on a tie the one
    // not granted last wins. Reset masks every grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (r0_req && r1_req) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = r0_req;
                gnt1 = r1_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        stage_d = stage_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = EXEC;
                    last_d  = gnt1;
                    id_d    = gnt1;
                    in1_d   = gnt1 ? r1_in1 : r0_in1;
                    in2_d   = gnt1 ? r1_in2 : r0_in2;
                    op_d    = gnt1 ? r1_op  : r0_op;
                end
            end
            EXEC: begin
                state_d = RESP;
                data_d  = alu_out;
                stage_d = alu_flag;
            end
            RESP: begin
                state_d = IDLE;
                flags_d = (flags_q & ~upd_mask) | (stage_q & upd_mask);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            stage_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            stage_q <= stage_d;
            flags_q <= flags_d;
        end
    end

    // Outputs are forced to 0 while rst is high, even in the
    // cycle before the registers have been cleared.
    always_comb begin
        r0_gnt      = gnt0;
        r1_gnt      = gnt1;
        alu_in1     = '0;
        alu_in2     = '0;
        alu_op      = '0;
        if (!rst && state_q == EXEC) begin
            alu_in1 = in1_q;
            alu_in2 = in2_q;
            alu_op  = op_q;
        end
        flag_q      = rst ? 3'b000 : flags_q;
        alu_flag_in = flag_q;
        rsp_valid   = !rst && state_q == RESP;
        rsp_id      = rst ? 1'b0 : id_q;
        rsp_data    = rst ? 16'h0000 : data_q;
        busy        = !rst && state_q != IDLE;
    end

endmodule
